// File: rtl/aes_ctr_sequencer_if.sv
// Handshake and operand bundle between the CTR-mode key/IV source, the keystream consumer and the AES core.
// master = environment (key source, stream side, AES core); slave = the sequencer itself.
interface aes_ctr_sequencer_if;
    logic         key_iv_valid;
    logic         key_iv_ready;
    logic [127:0] key_in;
    logic [127:0] iv_in;
    logic         key_and_sync_req;
    logic         key_and_sync_vld;
    logic         new_sync_req;
    logic         core_start;
    logic [127:0] core_key;
    logic [127:0] core_block;
    logic         core_done;
    logic [127:0] core_result;
    logic         cipher_block_vld;
    logic [127:0] cipher_block;
    logic         sync_overrun;

    modport master (
        output key_iv_valid, key_in, iv_in, key_and_sync_req, new_sync_req,
               core_done, core_result,
        input  key_iv_ready, key_and_sync_vld, core_start, core_key, core_block,
               cipher_block_vld, cipher_block, sync_overrun
    );

    modport slave (
        input  key_iv_valid, key_in, iv_in, key_and_sync_req, new_sync_req,
               core_done, core_result,
        output key_iv_ready, key_and_sync_vld, core_start, core_key, core_block,
               cipher_block_vld, cipher_block, sync_overrun
    );
endinterface

// File: rtl/aes_ctr_sequencer.sv
// AES-128 CTR sequencer: loads key/IV, issues one core request per counter block, returns the keystream block.
// Latency: key handshake -> core_start +1 cycle; core_done -> cipher_block_vld +1 cycle. Key/IV waits on key_iv_ready (LOAD only).
module aes_ctr_sequencer (
    input  logic                clk,
    input  logic                rst,
    aes_ctr_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        READY = 3'd4
    } state_t;

    state_t       state_q;
    logic [127:0] counter_q;
    logic [127:0] core_key_q;
    logic [127:0] core_block_q;
    logic [127:0] cipher_block_q;
    logic         key_iv_ready_q;
    logic         key_and_sync_vld_q;
    logic         core_start_q;
    logic         cipher_block_vld_q;
    logic         sync_overrun_q;
    logic         pending_q;

    logic [127:0] counter_inc_d;
    logic         key_fire_d;
    logic         sync_busy_d;

    // inc32: only the low word counts, no carry into the nonce part
    assign counter_inc_d = {counter_q[127:32], counter_q[31:0] + 32'd1};
    assign key_fire_d    = bus.key_iv_valid && key_iv_ready_q;
    assign sync_busy_d   = (state_q == LOAD) || (state_q == START) || (state_q == WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q            <= IDLE;
            counter_q          <= '0;
            core_key_q         <= '0;
            core_block_q       <= '0;
            cipher_block_q     <= '0;
            key_iv_ready_q     <= 1'b0;
            key_and_sync_vld_q <= 1'b0;
            core_start_q       <= 1'b0;
            cipher_block_vld_q <= 1'b0;
            sync_overrun_q     <= 1'b0;
            pending_q          <= 1'b0;
        end else begin
            key_and_sync_vld_q <= 1'b0;
            core_start_q       <= 1'b0;
            cipher_block_vld_q <= 1'b0;

            // Only one early sync request can be remembered; a second is an overrun
            if (bus.new_sync_req && sync_busy_d) begin
                if (pending_q) begin
                    sync_overrun_q <= 1'b1;
                end else begin
                    pending_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (bus.key_and_sync_req) begin
                        key_iv_ready_q <= 1'b1;
                        state_q        <= LOAD;
                    end
                end
                LOAD: begin
                    if (key_fire_d) begin
                        core_key_q         <= bus.key_in;
                        counter_q          <= bus.iv_in;
                        core_block_q       <= bus.iv_in;
                        key_iv_ready_q     <= 1'b0;
                        key_and_sync_vld_q <= 1'b1;
                        core_start_q       <= 1'b1;
                        state_q            <= START;
                    end
                end
                START: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (bus.core_done) begin
                        cipher_block_q     <= bus.core_result;
                        cipher_block_vld_q <= 1'b1;
                        counter_q          <= counter_inc_d;
                        state_q            <= READY;
                    end
                end
                READY: begin
                    // Next block beats a rekey when both are asked for together
                    if (bus.new_sync_req || pending_q) begin
                        pending_q    <= 1'b0;
                        core_block_q <= counter_q;
                        core_start_q <= 1'b1;
                        state_q      <= START;
                    end else if (bus.key_and_sync_req) begin
                        key_iv_ready_q <= 1'b1;
                        state_q        <= LOAD;
                    end
                end
                default: begin
                    key_iv_ready_q <= 1'b0;
                    state_q        <= IDLE;
                end
            endcase
        end
    end

    assign bus.key_iv_ready     = key_iv_ready_q;
    assign bus.key_and_sync_vld = key_and_sync_vld_q;
    assign bus.core_start       = core_start_q;
    assign bus.core_key         = core_key_q;
    assign bus.core_block       = core_block_q;
    assign bus.cipher_block_vld = cipher_block_vld_q;
    assign bus.cipher_block     = cipher_block_q;
    assign bus.sync_overrun     = sync_overrun_q;
endmodule

// File: doc/aes_ctr_sequencer.md
AES_CTR_SEQUENCER -- requirements
Module: aes_ctr_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port key_iv_valid, input, 1, key/IV source valid.
REQ-004 SHALL have port key_iv_ready, output, 1, sequencer accepts key/IV.
REQ-005 SHALL have port key_in, input, 128 (aes_model_pack::byte_table), AES-128 key.
REQ-006 SHALL have port iv_in, input, 128, initial counter block.
REQ-007 SHALL have port key_and_sync_req, input, 1, stream side requests a new key and sync.
REQ-008 SHALL have port key_and_sync_vld, output, 1, one-cycle pulse: key and sync loaded.
REQ-009 SHALL have port new_sync_req, input, 1, one-cycle pulse: next counter block needed.
REQ-010 SHALL have port core_start, output, 1, one-cycle start pulse to the AES core.
REQ-011 SHALL have ports core_key and core_block, output, 128 each, registered core operands.
REQ-012 SHALL have port core_done, input, 1, core result valid pulse.
REQ-013 SHALL have port core_result, input, 128, encrypted counter block.
REQ-014 SHALL have port cipher_block_vld, output, 1, one-cycle keystream-valid pulse.
REQ-015 SHALL have port cipher_block, output, 128, registered keystream block.
REQ-016 SHALL have port sync_overrun, output, 1, sticky error flag.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, START, WAIT, READY; all outputs registered.
REQ-018 IDLE: SHALL go to LOAD when key_and_sync_req=1.
REQ-019 LOAD: key_iv_ready=1; on key_iv_valid&key_iv_ready SHALL capture key_in to core_key and iv_in to counter, pulse key_and_sync_vld the next cycle, and go to START.
REQ-020 START: SHALL hold core_start=1 for exactly one cycle with core_block=counter, then go to WAIT.
REQ-021 WAIT: on core_done SHALL register core_result to cipher_block, pulse cipher_block_vld the next cycle, increment counter, and go to READY.
REQ-022 Counter increment SHALL be inc32: bits[31:0]+1 mod 2^32, bits[127:32] unchanged; 0xFFFFFFFF wraps to 0 with no carry.
REQ-023 READY: new_sync_req or pending flag SHALL go to START and clear the pending flag; otherwise key_and_sync_req=1 SHALL go to LOAD.
REQ-024 When new_sync_req and key_and_sync_req are both 1 in READY, new_sync_req SHALL win.
REQ-025 new_sync_req in LOAD/START/WAIT SHALL set a single pending flag; a second one while pending SHALL set sync_overrun.
REQ-026 core_done outside WAIT SHALL be ignored.
REQ-027 key_and_sync_req in START/WAIT SHALL be ignored until READY.
REQ-028 Latency: key handshake at cycle T -> key_and_sync_vld and core_start at T+1; core_done at D -> cipher_block_vld at D+1.
REQ-029 key_iv_ready SHALL be 1 only in LOAD.

Reset
REQ-030 On rst=0 SHALL enter IDLE and drive 0 on key_iv_ready, key_and_sync_vld, core_start, cipher_block_vld, and sync_overrun.
REQ-031 On rst=0 SHALL clear core_key, core_block, cipher_block, counter, and the pending flag to 0.
REQ-032 Reset mid-operation SHALL abort any core request; core_done after reset SHALL be ignored.
REQ-033 Only reset SHALL clear sync_overrun.

Verification
REQ-034 Reset release with key_and_sync_req=1, key_iv_valid=1, iv=0x...00000005 -> key_and_sync_vld pulse, core_start with core_block=..05; core_done at D -> cipher_block=core_result at D+1.
REQ-035 Three new_sync_req pulses, each after cipher_block_vld -> core_block ..06, ..07, ..08, one core_start each.
REQ-036 iv low word 0xFFFFFFFF, upper 0xA5.. -> second core_block low word 0x00000000, upper bits unchanged.
REQ-037 new_sync_req during WAIT -> START entered directly after READY; a second new_sync_req during WAIT -> sync_overrun=1 held until reset.
REQ-038 Both new_sync_req and key_and_sync_req in READY -> START taken, then LOAD taken on the next READY.
REQ-039 rst asserted during WAIT, then core_done -> no cipher_block_vld; FSM in IDLE; all outputs 0.
